store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 154 +++++++++++++++
 tb/tb_store_buffer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: in-order store queue between the pipeline and the data memory port.
// The queue is a circular FIFO, DEPTH entries deep. It drains one entry per cycle
// whenever no load needs the memory port.
// Each pending entry is compared with the current load address at 8-byte granularity,
// so that a load that overlaps a pending store can be stalled.
// Optional feature, enabled by defining STORE_BUF_FWD_EN:
//   When the youngest matching entry is a full doubleword store, its data is forwarded
//   to the load and the load is not stalled.

package store_buffer_pkg;
  typedef enum logic [2:0] {
    NO_STORE    = 3'd0,
    STORE_BYTE  = 3'd1,
    STORE_HALF  = 3'd2,
    STORE_WORD  = 3'd3,
    STORE_DWORD = 3'd4
  } mem_store_type_t;
endpackage

module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [63:0]              in_addr,
  input  logic [63:0]              in_data,
  input  mem_store_type_t          in_type,
  input  logic                     load_req,
  input  logic [63:0]              load_addr,
  output logic                     load_hit,
  output logic                     fwd_valid,
  output logic [63:0]              fwd_data,
  output logic [63:0]              mem_addr,
  output logic [63:0]              mem_data,
  output mem_store_type_t          mem_store_type,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [63:0]       addr_mem [DEPTH];
  logic [63:0]       data_mem [DEPTH];
  mem_store_type_t   type_mem [DEPTH];

  logic [PTR_W-1:0]  head_reg;
  logic [PTR_W-1:0]  tail_reg;
  logic [CNT_W-1:0]  count_reg;

  logic              enq;
  logic              drain;
  logic [DEPTH-1:0]  match_vec;
  logic              any_match;

  assign count    = count_reg;
  assign empty    = (count_reg == '0);
  assign in_ready = (count_reg < CNT_W'(DEPTH));
  // NO_STORE requests are accepted but never occupy an entry.
  assign enq      = in_valid && in_ready && (in_type != NO_STORE);
  assign drain    = !empty && !load_req;

  // Pointer and occupancy update; reset throws away every pending entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (enq)
        tail_reg <= tail_reg + 1'b1;
      if (drain)
        head_reg <= head_reg + 1'b1;
      case ({enq, drain})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Entry payload storage; only the pointers carry validity, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[tail_reg] <= in_addr;
      data_mem[tail_reg] <= in_data;
      type_mem[tail_reg] <= in_type;
    end
  end

  // Per-entry doubleword address compare, qualified by the entry lying inside the live window.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      logic [PTR_W-1:0] offset;
      assign offset        = PTR_W'(gi) - head_reg;
      assign match_vec[gi] = ({1'b0, offset} < count_reg) &&
                             (addr_mem[gi][63:3] == load_addr[63:3]);
    end
  endgenerate

  assign any_match = |match_vec;

`ifdef STORE_BUF_FWD_EN
  logic              yng_found;
  logic [PTR_W-1:0]  yng_idx;
  mem_store_type_t   yng_type;
  logic [63:0]       yng_data;

  // Walk oldest to youngest so the last hit seen is the youngest matching store.
  always_comb begin
    yng_found = 1'b0;
    yng_type  = NO_STORE;
    yng_data  = '0;
    yng_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      yng_idx = head_reg + PTR_W'(k);
      if (match_vec[yng_idx]) begin
        yng_found = 1'b1;
        yng_type  = type_mem[yng_idx];
        yng_data  = data_mem[yng_idx];
      end
    end
  end

  assign fwd_valid = !reset && load_req && yng_found && (yng_type == STORE_DWORD);
  assign fwd_data  = fwd_valid ? yng_data : 64'd0;
`else
  assign fwd_valid = 1'b0;
  assign fwd_data  = 64'd0;
`endif

  assign load_hit = !reset && load_req && any_match && !fwd_valid;

  // Memory port mux: a load owns the port, otherwise the head entry drains, otherwise idle.
  always_comb begin
    mem_addr       = '0;
    mem_data       = '0;
    mem_store_type = NO_STORE;
    if (!reset) begin
      if (load_req) begin
        mem_addr = load_addr;
      end else if (!empty) begin
        mem_addr       = addr_mem[head_reg];
        mem_data       = data_mem[head_reg];
        mem_store_type = type_mem[head_reg];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed self-checking bench for store_buffer (DEPTH = 4).

module tb_store_buffer;
  import store_buffer_pkg::*;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [63:0]     in_addr;
  logic [63:0]     in_data;
  mem_store_type_t in_type;
  logic            load_req;
  logic [63:0]     load_addr;
  logic            load_hit;
  logic            fwd_valid;
  logic [63:0]     fwd_data;
  logic [63:0]     mem_addr;
  logic [63:0]     mem_data;
  mem_store_type_t mem_store_type;
  logic [2:0]      count;
  logic            empty;

  int n_cmp = 0;
  int n_err = 0;

  store_buffer #(.DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_addr        (in_addr),
    .in_data        (in_data),
    .in_type        (in_type),
    .load_req       (load_req),
    .load_addr      (load_addr),
    .load_hit       (load_hit),
    .fwd_valid      (fwd_valid),
    .fwd_data       (fwd_data),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_store_type (mem_store_type),
    .count          (count),
    .empty          (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end else begin
      $display("PASS %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] a, input logic [63:0] d, input mem_store_type_t t);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_type  = t;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_addr   = '0;
    in_data   = '0;
    in_type   = NO_STORE;
    load_req  = 1'b1;
    load_addr = 64'h123;
    tick();
    tick();
    #1;
    // Outputs held quiet during reset even with a load requesting the port.
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_empty", empty, 1'b1);
    chk("rst_count", count, 3'd0);
    chk("rst_load_hit", load_hit, 1'b0);
    chk("rst_fwd_valid", fwd_valid, 1'b0);
    chk("rst_fwd_data", fwd_data, 64'd0);
    chk("rst_mem_type", mem_store_type, NO_STORE);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_data", mem_data, 64'd0);
    reset    = 1'b0;
    load_req = 1'b0;
    #1;
    chk("idle_mem_type", mem_store_type, NO_STORE);
    chk("idle_mem_addr", mem_addr, 64'd0);

    // Single store drains the next cycle.
    push(64'h100, 64'hDEADBEEF_CAFEF00D, STORE_DWORD);
    tick();
    in_valid = 1'b0;
    #1;
    chk("t1_count", count, 3'd1);
    chk("t1_mem_addr", mem_addr, 64'h100);
    chk("t1_mem_data", mem_data, 64'hDEADBEEF_CAFEF00D);
    chk("t1_mem_type", mem_store_type, STORE_DWORD);
    tick();
    chk("t1_empty", empty, 1'b1);
    chk("t1_mem_type_after", mem_store_type, NO_STORE);

    // NO_STORE is dropped.
    push(64'h180, 64'h1, NO_STORE);
    tick();
    in_valid = 1'b0;
    chk("nostore_empty", empty, 1'b1);

    // Fill with load_req held, overflow push ignored, then ordered drain.
    load_req  = 1'b1;
    load_addr = 64'h1000;
    for (int i = 0; i < 4; i++) begin
      push(64'h400 + 64'(8 * i), 64'(i + 1), STORE_DWORD);
      tick();
    end
    #1;
    chk("t2_count4", count, 3'd4);
    chk("t2_in_ready", in_ready, 1'b0);
    chk("t2_load_mem_addr", mem_addr, 64'h1000);
    chk("t2_load_mem_type", mem_store_type, NO_STORE);
    chk("t2_load_mem_data", mem_data, 64'd0);
    chk("t2_no_hit", load_hit, 1'b0);
    push(64'h500, 64'h55, STORE_DWORD);
    tick();
    in_valid = 1'b0;
    chk("t2_count_after5th", count, 3'd4);
    load_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_drain_addr", mem_addr, 64'h400 + 64'(8 * i));
      chk("t2_drain_data", mem_data, 64'(i + 1));
      tick();
    end
    chk("t2_empty", empty, 1'b1);

    // Overlap detection at doubleword granularity.
    load_req  = 1'b1;
    load_addr = 64'h200;
    push(64'h205, 64'hAB, STORE_BYTE);
    tick();
    in_valid = 1'b0;
    #1;
    chk("t3_hit", load_hit, 1'b1);
    chk("t3_fwd_valid", fwd_valid, 1'b0);
    load_addr = 64'h208;
    #1;
    chk("t3_nohit", load_hit, 1'b0);
    load_req = 1'b0;
    tick();
    chk("t3_empty", empty, 1'b1);

    // Youngest matching entry is a doubleword store.
    load_req  = 1'b1;
    load_addr = 64'h304;
    push(64'h300, 64'h55, STORE_WORD);
    tick();
    push(64'h300, 64'h11223344_55667788, STORE_DWORD);
    tick();
    in_valid = 1'b0;
    #1;
`ifdef STORE_BUF_FWD_EN
    chk("t4_fwd_valid", fwd_valid, 1'b1);
    chk("t4_fwd_data", fwd_data, 64'h11223344_55667788);
    chk("t4_load_hit", load_hit, 1'b0);
`else
    chk("t4_fwd_valid", fwd_valid, 1'b0);
    chk("t4_fwd_data", fwd_data, 64'd0);
    chk("t4_load_hit", load_hit, 1'b1);
`endif
    load_req = 1'b0;
    #1;
    chk("t4_drain_type0", mem_store_type, STORE_WORD);
    tick();
    chk("t4_drain_type1", mem_store_type, STORE_DWORD);
    tick();
    chk("t4_empty", empty, 1'b1);

    // Simultaneous push and drain at count 3, ten stores wrapping the pointers.
    load_req  = 1'b1;
    load_addr = 64'h9000;
    for (int s = 0; s < 3; s++) begin
      push(64'h600 + 64'(8 * s), 64'hA000 + 64'(s), STORE_DWORD);
      tick();
    end
    load_req = 1'b0;
    for (int c = 0; c < 7; c++) begin
      push(64'h600 + 64'(8 * (c + 3)), 64'hA000 + 64'(c + 3), STORE_DWORD);
      #1;
      chk("t5_count3", count, 3'd3);
      chk("t5_order_addr", mem_addr, 64'h600 + 64'(8 * c));
      chk("t5_order_data", mem_data, 64'hA000 + 64'(c));
      tick();
    end
    in_valid = 1'b0;
    for (int c = 7; c < 10; c++) begin
      #1;
      chk("t5_tail_addr", mem_addr, 64'h600 + 64'(8 * c));
      tick();
    end
    chk("t5_empty", empty, 1'b1);

    // Asynchronous reset in the middle of a drain.
    load_req = 1'b1;
    for (int s = 0; s < 3; s++) begin
      push(64'h700 + 64'(8 * s), 64'hB000 + 64'(s), STORE_DWORD);
      tick();
    end
    in_valid = 1'b0;
    load_req = 1'b0;
    #1;
    chk("t6_count3", count, 3'd3);
    chk("t6_draining", mem_store_type, STORE_DWORD);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_rst_count", count, 3'd0);
    chk("t6_rst_type", mem_store_type, NO_STORE);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t6_post_type", mem_store_type, NO_STORE);
      chk("t6_post_empty", empty, 1'b1);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
